// File: rtl/task_in_pkg.sv
//------------------------------------------------------------------------------
// Module   : task_in_pkg
// Purpose  : Shared types and addressing helper for the multi-bank task input.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package task_in_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  typedef enum logic [0:0] {
    WR_LOAD    = 1'b0,
    WR_DISCARD = 1'b1
  } wr_state_e;

  // Banks are laid out back to back in one flat memory.
  function automatic int unsigned bank_addr(input int unsigned bank,
                                            input int unsigned idx,
                                            input int unsigned nwords);
    return bank * nwords + idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdp_ram.sv
//------------------------------------------------------------------------------
// Module   : sdp_ram
// Purpose  : Simple dual-port RAM, one write port and one registered read port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 486,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register holds its value between reads so the output stays stable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/task_in_multibank.sv
//------------------------------------------------------------------------------
// Module   : task_in_multibank
// Purpose  : Round-robin multi-bank frame buffer feeding a request-driven core.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module task_in_multibank
  import task_in_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 243,
  parameter int NUM_BANKS  = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_tdata_valid,
  input  logic [DATA_WIDTH-1:0]            i_tdata,
  input  logic                             i_tdata_last,
  output logic                             o_tready,
  input  logic                             i_data_req,
  output logic                             o_frame_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_data_valid,
  output logic                             o_sof,
  output logic                             o_eof,
  output logic [$clog2(NUM_WORDS+1)-1:0]   o_frame_len,
  output logic                             o_overflow
);

  localparam int DEPTH  = NUM_BANKS * NUM_WORDS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int IDX_W  = $clog2(NUM_WORDS);
  localparam int LEN_W  = $clog2(NUM_WORDS + 1);

  bank_state_e           r_bank_state [NUM_BANKS];
  logic [LEN_W-1:0]      r_bank_len   [NUM_BANKS];
  logic [BANK_W-1:0]     r_wr_bank;
  logic [BANK_W-1:0]     r_rd_bank;
  logic [IDX_W-1:0]      r_wr_idx;
  logic [IDX_W-1:0]      r_rd_idx;
  wr_state_e             r_wr_state;
  wr_state_e             w_wr_state_nxt;
  logic                  r_overflow;
  logic                  r_data_valid;
  logic                  r_sof;
  logic                  r_eof;

  logic                  w_load_ok;
  logic                  w_tready;
  logic                  w_accept;
  logic                  w_store;
  logic                  w_wr_last_slot;
  logic                  w_close;
  logic                  w_trunc;
  logic                  w_frame_ready;
  logic                  w_rd_fire;
  logic [LEN_W-1:0]      w_rd_len;
  logic                  w_rd_is_last;
  logic [ADDR_W-1:0]     w_wr_addr;
  logic [ADDR_W-1:0]     w_rd_addr;

  function automatic logic [BANK_W-1:0] f_next_bank(input logic [BANK_W-1:0] b);
    return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
  endfunction

  assign w_load_ok = (r_bank_state[r_wr_bank] == BANK_EMPTY) ||
                     (r_bank_state[r_wr_bank] == BANK_FILLING);
  assign w_wr_last_slot = (r_wr_idx == IDX_W'(NUM_WORDS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_state <= WR_LOAD;
    end else begin
      r_wr_state <= w_wr_state_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_tready       = 1'b0;
    case (r_wr_state)
      WR_LOAD: begin
        w_tready = !i_rst && w_load_ok;
        if (!i_rst && i_tdata_valid && w_load_ok && !i_tdata_last && w_wr_last_slot) begin
          w_wr_state_nxt = WR_DISCARD;
        end
      end
      WR_DISCARD: begin
        w_tready = !i_rst;
        if (!i_rst && i_tdata_valid && i_tdata_last) begin
          w_wr_state_nxt = WR_LOAD;
        end
      end
      default: begin
        w_wr_state_nxt = WR_LOAD;
      end
    endcase
  end

  assign w_accept = i_tdata_valid && w_tready;
  assign w_store  = w_accept && (r_wr_state == WR_LOAD);
  assign w_close  = w_store && (i_tdata_last || w_wr_last_slot);
  assign w_trunc  = w_store && !i_tdata_last && w_wr_last_slot;

  assign w_frame_ready = (r_bank_state[r_rd_bank] == BANK_FULL) ||
                         (r_bank_state[r_rd_bank] == BANK_DRAINING);
  assign w_rd_fire     = i_data_req && w_frame_ready;
  assign w_rd_len      = r_bank_len[r_rd_bank];
  assign w_rd_is_last  = (LEN_W'(r_rd_idx) == (w_rd_len - LEN_W'(1)));

  // Write and read always target different banks: a bank being written is
  // EMPTY/FILLING while the read side only touches FULL/DRAINING banks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_bank_state[b] <= BANK_EMPTY;
        r_bank_len[b]   <= '0;
      end
      r_wr_bank    <= '0;
      r_rd_bank    <= '0;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_overflow   <= 1'b0;
      r_data_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
    end else begin
      if (w_store) begin
        if (w_close) begin
          r_bank_state[r_wr_bank] <= BANK_FULL;
          r_bank_len[r_wr_bank]   <= LEN_W'(r_wr_idx) + LEN_W'(1);
          r_wr_bank               <= f_next_bank(r_wr_bank);
          r_wr_idx                <= '0;
        end else begin
          r_bank_state[r_wr_bank] <= BANK_FILLING;
          r_wr_idx                <= r_wr_idx + 1'b1;
        end
      end
      if (w_trunc) begin
        r_overflow <= 1'b1;
      end
      if (w_rd_fire) begin
        if (w_rd_is_last) begin
          r_bank_state[r_rd_bank] <= BANK_EMPTY;
          r_rd_bank               <= f_next_bank(r_rd_bank);
          r_rd_idx                <= '0;
        end else begin
          r_bank_state[r_rd_bank] <= BANK_DRAINING;
          r_rd_idx                <= r_rd_idx + 1'b1;
        end
      end
      r_data_valid <= w_rd_fire;
      r_sof        <= w_rd_fire && (r_rd_idx == '0);
      r_eof        <= w_rd_fire && w_rd_is_last;
    end
  end

  assign w_wr_addr = ADDR_W'(bank_addr(32'(r_wr_bank), 32'(r_wr_idx), NUM_WORDS));
  assign w_rd_addr = ADDR_W'(bank_addr(32'(r_rd_bank), 32'(r_rd_idx), NUM_WORDS));

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_store),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (i_tdata),
    .i_rd_en   (w_rd_fire),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (o_data)
  );

  assign o_tready      = w_tready;
  assign o_frame_ready = w_frame_ready;
  assign o_data_valid  = r_data_valid;
  assign o_sof         = r_sof;
  assign o_eof         = r_eof;
  assign o_frame_len   = w_rd_len;
  assign o_overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_task_in_multibank.sv
//------------------------------------------------------------------------------
// Module   : tb_task_in_multibank
// Purpose  : Directed self-checking bench for task_in_multibank.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_task_in_multibank;

  localparam int DW = 8;
  localparam int NW = 243;
  localparam int NB = 2;
  localparam int LW = $clog2(NW + 1);

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_tdata_valid = 1'b0;
  logic [DW-1:0] i_tdata = '0;
  logic          i_tdata_last = 1'b0;
  logic          o_tready;
  logic          i_data_req = 1'b0;
  logic          o_frame_ready;
  logic [DW-1:0] o_data;
  logic          o_data_valid;
  logic          o_sof;
  logic          o_eof;
  logic [LW-1:0] o_frame_len;
  logic          o_overflow;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q [$];
  logic       tready_log [512];

  always #5 clk = ~clk;

  task_in_multibank #(
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW),
    .NUM_BANKS  (NB)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_tdata_valid (i_tdata_valid),
    .i_tdata       (i_tdata),
    .i_tdata_last  (i_tdata_last),
    .o_tready      (o_tready),
    .i_data_req    (i_data_req),
    .o_frame_ready (o_frame_ready),
    .o_data        (o_data),
    .o_data_valid  (o_data_valid),
    .o_sof         (o_sof),
    .o_eof         (o_eof),
    .o_frame_len   (o_frame_len),
    .o_overflow    (o_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int n = 0;
    i_tdata_valid = 1'b1;
    i_tdata       = d;
    i_tdata_last  = last;
    while (!o_tready && n < 2000) begin
      step();
      n++;
    end
    if (!o_tready) begin
      total++; bad++;
      $display("FAIL send_timeout beat=%0h tready=%b required=1", d, o_tready);
    end
    step();
    i_tdata_valid = 1'b0;
    i_tdata_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) send_beat(8'(int'(base) + i), i == len - 1);
  endtask

  task automatic push_frame(input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back({i == 0, i == len - 1, 8'(int'(base) + i)});
  endtask

  task automatic read_words(input int n, input string tag);
    logic [9:0] e;
    i_data_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      tready_log[k] = o_tready;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3ff;
      total++;
      if ({o_data_valid, o_sof, o_eof, o_data} !== {1'b1, e}) begin
        bad++;
        $display("FAIL %s word=%0d got v/sof/eof/data=%b%b%b/%02h required=1%b%b/%02h",
                 tag, k, o_data_valid, o_sof, o_eof, o_data, e[9], e[8], e[7:0]);
      end
      if (k == n - 1) i_data_req = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    total++;
    if ({o_tready, o_frame_ready, o_data_valid, o_sof, o_eof, o_overflow, o_data} !== '0) begin
      bad++;
      $display("FAIL %s got rdy/frdy/v/sof/eof/ovf/data=%b%b%b%b%b%b/%02h required=all 0",
               tag, o_tready, o_frame_ready, o_data_valid, o_sof, o_eof, o_overflow, o_data);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) step();
    check_zero("reset_outputs");
    i_rst = 1'b0;
    step();
    total++;
    if ({o_tready, o_frame_ready} !== 2'b10) begin
      bad++;
      $display("FAIL reset_release got tready/frame_ready=%b%b required=10", o_tready, o_frame_ready);
    end
  endtask

  task automatic test_full_frame();
    push_frame(8'h00, NW);
    send_frame(8'h00, NW);
    total++;
    if ({o_frame_ready, o_frame_len} !== {1'b1, LW'(NW)}) begin
      bad++;
      $display("FAIL full_ready got ready=%b len=%0d required ready=1 len=%0d", o_frame_ready, o_frame_len, NW);
    end
    read_words(NW, "full_frame");
    step();
    total++;
    if ({o_data_valid, o_frame_ready} !== 2'b00) begin
      bad++;
      $display("FAIL full_after got valid/ready=%b%b required=00", o_data_valid, o_frame_ready);
    end
  endtask

  task automatic test_backpressure();
    push_frame(8'h30, 10);
    push_frame(8'h40, 10);
    send_frame(8'h30, 10);
    send_frame(8'h40, 10);
    repeat (3) step();
    total++;
    if (o_tready !== 1'b0) begin
      bad++;
      $display("FAIL bp_stall got tready=%b required=0", o_tready);
    end
    read_words(10, "bp_frame_a");
    total++;
    if ({tready_log[8], tready_log[9]} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release got tready(word8,word9)=%b%b required=01", tready_log[8], tready_log[9]);
    end
    push_frame(8'h50, 10);
    send_frame(8'h50, 10);
    read_words(20, "bp_frames_bc");
  endtask

  task automatic test_back_to_back();
    push_frame(8'h60, 6);
    send_frame(8'h60, 6);
    push_frame(8'h70, 6);
    fork
      send_frame(8'h70, 6);
      read_words(12, "b2b_stream");
    join
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 250; i++) send_beat(8'(i), i == 249);
    total++;
    if ({o_overflow, o_frame_ready, o_frame_len} !== {2'b11, LW'(NW)}) begin
      bad++;
      $display("FAIL ovf_state got ovf=%b ready=%b len=%0d required ovf=1 ready=1 len=%0d",
               o_overflow, o_frame_ready, o_frame_len, NW);
    end
    push_frame(8'h00, NW);
    read_words(NW, "ovf_frame");
    push_frame(8'h80, 5);
    send_frame(8'h80, 5);
    total++;
    if ({o_frame_len, o_overflow} !== {LW'(5), 1'b1}) begin
      bad++;
      $display("FAIL ovf_next got len=%0d ovf=%b required len=5 ovf=1", o_frame_len, o_overflow);
    end
    read_words(5, "ovf_next_frame");
  endtask

  task automatic test_one_word();
    i_data_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (o_data_valid !== 1'b0) begin
        bad++;
        $display("FAIL empty_req cycle=%0d got valid=%b required=0", k, o_data_valid);
      end
    end
    i_data_req = 1'b0;
    push_frame(8'hA5, 1);
    send_frame(8'hA5, 1);
    total++;
    if ({o_frame_ready, o_frame_len} !== {1'b1, LW'(1)}) begin
      bad++;
      $display("FAIL one_len got ready=%b len=%0d required ready=1 len=1", o_frame_ready, o_frame_len);
    end
    read_words(1, "one_word");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 100; i++) send_beat(8'(i), 1'b0);
    i_rst = 1'b1;
    step();
    check_zero("rst_mid_load");
    i_rst = 1'b0;
    step();
    total++;
    if ({o_frame_ready, o_data_valid, o_overflow} !== 3'b000) begin
      bad++;
      $display("FAIL rst_load_after got ready/valid/ovf=%b%b%b required=000", o_frame_ready, o_data_valid, o_overflow);
    end
    send_frame(8'h90, 20);
    i_data_req = 1'b1;
    repeat (5) step();
    i_rst = 1'b1;
    i_data_req = 1'b0;
    step();
    check_zero("rst_mid_drain");
    i_rst = 1'b0;
    step();
    step();
    total++;
    if ({o_frame_ready, o_data_valid, o_sof, o_eof} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_drain_after got ready/valid/sof/eof=%b%b%b%b required=0000",
               o_frame_ready, o_data_valid, o_sof, o_eof);
    end
    push_frame(8'hC0, 4);
    send_frame(8'hC0, 4);
    total++;
    if (o_frame_len !== LW'(4)) begin
      bad++;
      $display("FAIL rst_new_len got len=%0d required=4", o_frame_len);
    end
    read_words(4, "rst_new_frame");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_one_word();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected got=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
